avalon_pio_irq: RTL and testbench

AVALON_PIO_IRQ -- requirements
Module: avalon_pio_irq

---
 rtl/avalon_pio_pkg.sv | 21 ++
 rtl/pio_sync_edge.sv | 52 +++++
 rtl/avalon_pio_irq.sv | 113 +++++++++++
 tb/tb_avalon_pio_irq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pio_pkg.sv
// Shared constants for the Avalon PIO with interrupt support.
//   - Register word offsets on the Avalon-MM slave.
//   - EDGE_* encodings for the edge-capture polarity.
//   - IRQ_* encodings for the interrupt source.
package avalon_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  localparam int unsigned IRQ_LEVEL = 0;
  localparam int unsigned IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_sync_edge.sv
// Input conditioning for the PIO: 2-flop synchronizer, one-cycle delayed
// copy and a per-bit edge detector gated by a warm-up counter.
//   clk, reset_n : clock, async active-low reset
//   in_port_i    : raw asynchronous pins
//   in_sync_o    : synchronized pins
//   edge_o       : one-cycle edge pulses (polarity chosen by EDGE_TYPE)
module pio_sync_edge
  import avalon_pio_pkg::*;
#(
  parameter int unsigned WIDTH     = 18,
  parameter int unsigned EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port_i,
  output logic [WIDTH-1:0] in_sync_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] sync1_q, sync2_q, in_d_q;
  logic [1:0]       warm_q;
  logic [WIDTH-1:0] edge_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      in_d_q  <= '0;
      warm_q  <= 2'd0;
    end else begin
      sync1_q <= in_port_i;
      sync2_q <= sync1_q;
      in_d_q  <= sync2_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  edge_raw = sync2_q & ~in_d_q;
      EDGE_FALLING: edge_raw = ~sync2_q & in_d_q;
      default:      edge_raw = sync2_q ^ in_d_q;
    endcase
  end

  // Pipeline flops still hold reset zeros until the counter saturates, so any
  // difference seen before then is an artefact of reset release, not a pin edge.
  assign edge_o    = (warm_q == 2'd3) ? edge_raw : '0;
  assign in_sync_o = sync2_q;

endmodule

// File: rtl/avalon_pio_irq.sv
// Avalon-MM parallel I/O port with edge capture and interrupt.
//   clk, reset_n                         : clock, async active-low reset
//   address, chipselect, write_n,
//   writedata, readdata                  : Avalon-MM slave, zero-wait reads
//   in_port                              : asynchronous pin inputs
//   out_port                             : data_out register
//   oe                                   : per-bit output enable (dir)
//   irq                                  : registered level interrupt
module avalon_pio_irq
  import avalon_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 18,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      EDGE_TYPE   = EDGE_RISING,
  parameter int unsigned      IRQ_TYPE    = IRQ_EDGE,
  parameter int unsigned      BIDIR       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [WIDTH-1:0] DirReset = (BIDIR != 0) ? '0 : '1;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ec_q, ec_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] in_sync, edge_det, wdata, rd_w, irq_src;
  logic             wr_en;
  logic             unused_writedata;

  pio_sync_edge #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port_i (in_port),
    .in_sync_o (in_sync),
    .edge_o    (edge_det)
  );

  assign wr_en            = chipselect & ~write_n;
  assign wdata            = writedata[WIDTH-1:0];
  assign unused_writedata = ^writedata;

  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    ec_d   = ec_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:    data_d = wdata;
        ADDR_DIR:     if (BIDIR != 0) dir_d = wdata;
        ADDR_IRQMASK: mask_d = wdata;
        ADDR_EDGECAP: ec_d   = ec_q & ~wdata;
        ADDR_OUTSET:  data_d = data_q | wdata;
        ADDR_OUTCLR:  data_d = data_q & ~wdata;
        default:      ;
      endcase
    end
    // Applied after the clear so a same-cycle edge keeps its bit set.
    ec_d = ec_d | edge_det;
  end

  assign irq_src = (IRQ_TYPE == IRQ_LEVEL) ? in_sync : ec_q;
  assign irq_d   = |(irq_src & mask_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      dir_q  <= DirReset;
      mask_q <= '0;
      ec_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      ec_q   <= ec_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    rd_w = '0;
    case (address)
      ADDR_DATA:    rd_w = (in_sync & ~dir_q) | (data_q & dir_q);
      ADDR_DIR:     rd_w = dir_q;
      ADDR_IRQMASK: rd_w = mask_q;
      ADDR_EDGECAP: rd_w = ec_q;
      default:      rd_w = '0;
    endcase
  end

  assign readdata = 32'(rd_w);
  assign out_port = data_q;
  assign oe       = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_avalon_pio_irq.sv
module tb_avalon_pio_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;

  logic [17:0] in_a, out_a, oe_a;
  logic [17:0] in_b, out_b, oe_b;
  logic [3:0]  in_c, out_c, oe_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avalon_pio_irq #(
    .WIDTH(18), .RESET_VALUE(18'h2AAAA), .EDGE_TYPE(0), .IRQ_TYPE(1), .BIDIR(0)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_a),
    .out_port(out_a), .oe(oe_a), .irq(irq_a)
  );

  avalon_pio_irq #(
    .WIDTH(18), .RESET_VALUE(18'h0), .EDGE_TYPE(0), .IRQ_TYPE(1), .BIDIR(1)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b), .in_port(in_b),
    .out_port(out_b), .oe(oe_b), .irq(irq_b)
  );

  avalon_pio_irq #(
    .WIDTH(4), .RESET_VALUE(4'h0), .EDGE_TYPE(1), .IRQ_TYPE(0), .BIDIR(0)
  ) u_dut_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_c), .in_port(in_c),
    .out_port(out_c), .oe(oe_c), .irq(irq_c)
  );

  typedef struct {
    logic        cs;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [17:0] exp_out;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    // Register-access vectors for instance A (BIDIR=0, so address 0 reads data_out).
    vecs[0]  = '{1'b1, 1'b1, 3'd0, 32'h0000_00F0, 32'h0000_00F0, 18'h000F0};
    vecs[1]  = '{1'b1, 1'b1, 3'd4, 32'h0000_0003, 32'h0000_0000, 18'h000F3};
    vecs[2]  = '{1'b1, 1'b1, 3'd5, 32'h0000_0010, 32'h0000_0000, 18'h000E3};
    vecs[3]  = '{1'b1, 1'b1, 3'd1, 32'h0000_0000, 32'h0003_FFFF, 18'h000E3};
    vecs[4]  = '{1'b1, 1'b1, 3'd2, 32'h0000_0001, 32'h0000_0001, 18'h000E3};
    vecs[5]  = '{1'b0, 1'b1, 3'd0, 32'h0000_1234, 32'h0000_00E3, 18'h000E3};
    vecs[6]  = '{1'b1, 1'b0, 3'd0, 32'h0000_5555, 32'h0000_00E3, 18'h000E3};
    vecs[7]  = '{1'b1, 1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0000_0000, 18'h000E3};
    vecs[8]  = '{1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0003_FFFF, 18'h3FFFF};
    vecs[9]  = '{1'b1, 1'b1, 3'd5, 32'hFFFF_0000, 32'h0000_0000, 18'h0FFFF};
    vecs[10] = '{1'b1, 1'b1, 3'd3, 32'h0000_0000, 32'h0000_0000, 18'h0FFFF};

    reset_n    = 1'b0;
    address    = 3'd3;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_a       = '1;
    in_b       = 18'h003A0;
    in_c       = '0;
    #22;
    reset_n = 1'b1;
    #1;

    // Reset state; pins high at release must not be captured as edges.
    check("oe_a_reset", 32'(oe_a), 32'h3FFFF);
    check("oe_b_reset", 32'(oe_b), 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("out_a_reset", 32'(out_a), 32'h2AAAA);
      check("ec_a_reset", rd_a, 32'h0);
      check("irq_a_reset", 32'(irq_a), 32'h0);
    end
    check("ec_b_reset", rd_b, 32'h0);

    in_a = '0;
    repeat (5) step();

    for (int i = 0; i < 11; i++) begin
      address    = vecs[i].addr;
      writedata  = vecs[i].wdata;
      chipselect = vecs[i].cs;
      write_n    = ~vecs[i].wr;
      step();
      chipselect = 1'b0;
      write_n    = 1'b1;
      check($sformatf("vec%0d_out", i), 32'(out_a), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d_rd", i), rd_a, vecs[i].exp_rd);
    end

    // Rising edge on bit 0 -> capture at 3rd edge, irq one cycle later.
    address = 3'd3;
    in_a[0] = 1'b1;
    step();
    step();
    check("ec0_edge2", rd_a, 32'h0);
    step();
    check("ec0_edge3", rd_a, 32'h1);
    check("irq_edge3", 32'(irq_a), 32'h0);
    step();
    check("irq_edge4", 32'(irq_a), 32'h1);
    do_write(3'd3, 32'h1);
    check("ec0_w1c", rd_a, 32'h0);
    check("irq_w1c_1", 32'(irq_a), 32'h1);
    step();
    check("irq_w1c_2", 32'(irq_a), 32'h0);

    // Bit 2: capture, ignore falling, then edge coincident with W1C.
    in_a[2] = 1'b1;
    repeat (3) step();
    check("ec2_set", rd_a, 32'h4);
    in_a[2] = 1'b0;
    repeat (4) step();
    check("ec2_fall_ignored", rd_a, 32'h4);
    in_a[2] = 1'b1;
    step();
    step();
    do_write(3'd3, 32'h4);
    check("ec2_set_wins", rd_a, 32'h4);
    check("irq_unmasked_bit", 32'(irq_a), 32'h0);
    do_write(3'd3, 32'h4);
    check("ec2_w1c", rd_a, 32'h0);

    // Bidirectional read mux and ignored dir writes.
    do_write(3'd1, 32'h0000_000F);
    do_write(3'd0, 32'h0000_0005);
    check("oe_b_dir", 32'(oe_b), 32'h0000F);
    check("out_b_data", 32'(out_b), 32'h00005);
    check("rd_b_mux", rd_b, 32'h0000_03A5);
    address = 3'd1;
    #1;
    check("rd_b_dir", rd_b, 32'h0000_000F);
    check("rd_a_dir_fixed", rd_a, 32'h0003_FFFF);
    check("oe_a_fixed", 32'(oe_a), 32'h3FFFF);

    // Instance C: falling-edge capture with level interrupt.
    address = 3'd3;
    in_c[0] = 1'b1;
    step();
    step();
    check("irq_c_lvl_edge2", 32'(irq_c), 32'h0);
    step();
    check("irq_c_lvl_edge3", 32'(irq_c), 32'h1);
    check("ec_c_rise_ignored", rd_c, 32'h0);
    in_c[0] = 1'b0;
    step();
    step();
    check("irq_c_hold", 32'(irq_c), 32'h1);
    step();
    check("ec_c_fall", rd_c, 32'h1);
    check("irq_c_low", 32'(irq_c), 32'h0);

    // Mid-operation reset restarts warm-up; held-high pin is not captured.
    in_a[1] = 1'b1;
    step();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    check("out_a_rereset", 32'(out_a), 32'h2AAAA);
    repeat (5) step();
    check("ec_a_rereset", rd_a, 32'h0);
    check("irq_a_rereset", 32'(irq_a), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
